// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the four active-low board LEDs between NREQ requesters, with an idle chase.
// Optional build macro LED_SHARE_DIM_EN dims the idle chase to a 25% duty cycle.
module led_share_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned DIV_W       = 22,
    parameter int unsigned HOLD_TICKS  = 8,
    parameter int unsigned CHASE_TICKS = 4
) (
    input  logic              osc_clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] pat,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [3:0]        LED
);
    localparam int unsigned RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW  = $clog2(HOLD_TICKS + 1);
    localparam int unsigned CW  = $clog2(CHASE_TICKS + 1);

    typedef enum logic [1:0] {StIdle, StShow, StRelease} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [RRW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [RRW-1:0]    winner_q, winner_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     chase_cnt_q, chase_cnt_d;
    logic [1:0]        chase_idx_q, chase_idx_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic              busy_q, busy_d;
    logic [3:0]        led_q, led_d;

    logic              tick;
    logic              found;
    logic [RRW-1:0]    arb_idx, arb_next;
    logic [NREQ-1:0]   arb_oh, win_oh;
    logic [3:0]        win_pat;
    logic              req_win;
    logic              do_show, do_idle;
    int                idx;

    assign tick = &div_q;

    // Search starts at rr_ptr and wraps with an explicit compare so non-power-of-2 NREQ works.
    always_comb begin
        found   = 1'b0;
        arb_idx = '0;
        idx     = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (!found && req[RRW'(idx)]) begin
                found   = 1'b1;
                arb_idx = RRW'(idx);
            end
        end
        arb_next = (int'(arb_idx) + 1 >= int'(NREQ)) ? '0 : arb_idx + RRW'(1);
    end

    always_comb begin
        arb_oh  = '0;
        win_oh  = '0;
        win_pat = '0;
        req_win = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            arb_oh[i] = (arb_idx == RRW'(i));
            win_oh[i] = (winner_q == RRW'(i));
            if (arb_idx == RRW'(i)) win_pat = pat[4*i +: 4];
            if (winner_q == RRW'(i)) req_win = req[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q + DIV_W'(1);
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        hold_d      = hold_q;
        chase_cnt_d = chase_cnt_q;
        chase_idx_d = chase_idx_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        busy_d      = busy_q;
        led_d       = led_q;
        do_show     = 1'b0;
        do_idle     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    if (chase_cnt_q + CW'(1) == CW'(CHASE_TICKS)) begin
                        chase_cnt_d = '0;
                        chase_idx_d = chase_idx_q + 2'd1;
                    end else begin
                        chase_cnt_d = chase_cnt_q + CW'(1);
                    end
                end
                do_show = found;
            end
            StShow: begin
                // A dropped request wins over a coinciding final tick: no done pulse.
                if (!req_win) begin
                    state_d = StRelease;
                    gnt_d   = '0;
                    led_d   = 4'b1111;
                end else if (tick) begin
                    hold_d = hold_q + HW'(1);
                    if (hold_q + HW'(1) == HW'(HOLD_TICKS)) begin
                        state_d = StRelease;
                        gnt_d   = '0;
                        led_d   = 4'b1111;
                        done_d  = win_oh;
                    end
                end
            end
            StRelease: begin
                do_show = found;
                do_idle = !found;
            end
            default: do_idle = 1'b1;
        endcase

        if (do_show) begin
            state_d  = StShow;
            div_d    = '0;
            winner_d = arb_idx;
            rr_ptr_d = arb_next;
            hold_d   = '0;
            gnt_d    = arb_oh;
            busy_d   = 1'b1;
            led_d    = ~win_pat;
        end
        if (do_idle) begin
            state_d     = StIdle;
            div_d       = '0;
            chase_cnt_d = '0;
            chase_idx_d = '0;
            gnt_d       = '0;
            busy_d      = 1'b0;
        end
        if (state_d == StIdle) begin
`ifdef LED_SHARE_DIM_EN
            led_d = (div_d[1:0] == 2'b00) ? ~(4'b0001 << chase_idx_d) : 4'b1111;
`else
            led_d = ~(4'b0001 << chase_idx_d);
`endif
        end
    end

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            div_q       <= '0;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            hold_q      <= '0;
            chase_cnt_q <= '0;
            chase_idx_q <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            led_q       <= 4'b1110;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            hold_q      <= hold_d;
            chase_cnt_q <= chase_cnt_d;
            chase_idx_q <= chase_idx_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            led_q       <= led_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign LED  = led_q;
endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter at DIV_W=4, HOLD_TICKS=3, CHASE_TICKS=2, NREQ=4.
// Build with LED_SHARE_DIM_EN defined to also exercise the dimmed idle chase.
module tb_led_share_arbiter;
    logic        osc_clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] pat;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  LED;

    int n_checks = 0;
    int n_errs   = 0;

`ifdef LED_SHARE_DIM_EN
    localparam logic [3:0] IdleLed31 = 4'b1111;
`else
    localparam logic [3:0] IdleLed31 = 4'b1110;
`endif

    led_share_arbiter #(
        .NREQ       (4),
        .DIV_W      (4),
        .HOLD_TICKS (3),
        .CHASE_TICKS(2)
    ) dut (
        .osc_clk(osc_clk),
        .rst_n  (rst_n),
        .req    (req),
        .pat    (pat),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .LED    (LED)
    );

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge osc_clk);
    endtask

    logic [3:0] rr_led [4];
    int lit, dark;

    initial begin
        rr_led[0] = 4'hC;  // ~4'h3
        rr_led[1] = 4'h9;  // ~4'h6
        rr_led[2] = 4'h3;  // ~4'hC
        rr_led[3] = 4'h6;  // ~4'h9
        rst_n = 1'b0;
        req   = '0;
        pat   = '0;
        wait_cycles(3);
        rst_n = 1'b1;

        // Reset state and idle chase
        check_eq("rst_led", 32'(LED), 32'h E);
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        wait_cycles(31);
        check_eq("chase_31", 32'(LED), 32'(IdleLed31));
        wait_cycles(1);
        check_eq("chase_32", 32'(LED), 32'hD);
        wait_cycles(32);
        check_eq("chase_64", 32'(LED), 32'hB);
        wait_cycles(64);
        check_eq("chase_wrap", 32'(LED), 32'hE);

        // Single request
        pat = 16'h000A;
        req = 4'b0001;
        wait_cycles(1);
        check_eq("single_gnt", 32'(gnt), 32'h1);
        check_eq("single_led", 32'(LED), 32'h5);
        check_eq("single_busy", 32'(busy), 32'h1);
        wait_cycles(47);
        check_eq("single_hold_gnt", 32'(gnt), 32'h1);
        check_eq("single_hold_done", 32'(done), 32'h0);
        wait_cycles(1);
        check_eq("single_rel_led", 32'(LED), 32'hF);
        check_eq("single_rel_done", 32'(done), 32'h1);
        check_eq("single_rel_gnt", 32'(gnt), 32'h0);
        check_eq("single_rel_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        wait_cycles(1);
        check_eq("single_idle_led", 32'(LED), 32'hE);
        check_eq("single_idle_busy", 32'(busy), 32'h0);
        check_eq("single_idle_done", 32'(done), 32'h0);

        // Reset in IDLE returns rr_ptr to 0
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;

        // Round-robin across all four, wrapping back to 0
        pat = 16'h9C63;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_cycles(1);
            check_eq($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
            check_eq($sformatf("rr%0d_led", g), 32'(LED), 32'(rr_led[g % 4]));
            wait_cycles(47);
            check_eq($sformatf("rr%0d_hold", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
            wait_cycles(1);
            check_eq($sformatf("rr%0d_rel_led", g), 32'(LED), 32'hF);
            check_eq($sformatf("rr%0d_rel_done", g), 32'(done), 32'(4'b0001 << (g % 4)));
        end

        // Pattern latch on requester 1
        wait_cycles(1);
        check_eq("latch_gnt", 32'(gnt), 32'h2);
        wait_cycles(10);
        pat = 16'h9CF3;
        wait_cycles(1);
        check_eq("latch_led_a", 32'(LED), 32'h9);
        wait_cycles(36);
        check_eq("latch_led_b", 32'(LED), 32'h9);
        wait_cycles(1);
        check_eq("latch_rel_done", 32'(done), 32'h2);

        // Abort on requester 2
        wait_cycles(1);
        check_eq("abort_gnt", 32'(gnt), 32'h4);
        check_eq("abort_led", 32'(LED), 32'h3);
        wait_cycles(9);
        req = 4'b1011;
        wait_cycles(1);
        check_eq("abort_rel_gnt", 32'(gnt), 32'h0);
        check_eq("abort_rel_led", 32'(LED), 32'hF);
        check_eq("abort_rel_done", 32'(done), 32'h0);
        check_eq("abort_rel_busy", 32'(busy), 32'h1);
        wait_cycles(1);
        check_eq("abort_next_gnt", 32'(gnt), 32'h8);
        check_eq("abort_next_led", 32'(LED), 32'h6);
        wait_cycles(47);
        wait_cycles(1);
        check_eq("r3_rel_done", 32'(done), 32'h8);
        wait_cycles(1);
        check_eq("r0_gnt", 32'(gnt), 32'h1);

        // Reset mid-SHOW with rr_ptr at 1
        wait_cycles(5);
        rst_n = 1'b0;
        req   = 4'b0011;
        #1;
        check_eq("mid_rst_gnt", 32'(gnt), 32'h0);
        check_eq("mid_rst_led", 32'(LED), 32'hE);
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_done", 32'(done), 32'h0);
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(1);
        check_eq("post_rst_gnt", 32'(gnt), 32'h1);
        check_eq("post_rst_led", 32'(LED), 32'hC);
        wait_cycles(48);
        check_eq("post_rst_done", 32'(done), 32'h1);
        req = 4'b0000;
        wait_cycles(1);
        check_eq("final_idle_led", 32'(LED), 32'hE);
        check_eq("final_idle_busy", 32'(busy), 32'h0);

`ifdef LED_SHARE_DIM_EN
        lit  = 0;
        dark = 0;
        for (int c = 0; c < 16; c++) begin
            wait_cycles(1);
            if (LED == 4'hE) lit++;
            if (LED == 4'hF) dark++;
        end
        check_eq("dim_lit", 32'(lit), 32'd4);
        check_eq("dim_dark", 32'(dark), 32'd12);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Shares the board's 4 active-low LEDs between NREQ requesters. Each requester asks to show a 4-bit pattern for a fixed hold time.
- Grants are round-robin, timed by an internal prescaler, with a one-hot chase shown when nobody is requesting.
- Sits between the internal-oscillator clock domain logic and the LED pins, replacing direct LED drive.

Parameters:
- NREQ, 4, number of requesters; legal range 1..8.
- DIV_W, 22, prescaler width; one tick = 2^DIV_W clocks.
- HOLD_TICKS, 8, ticks a granted pattern stays on the LEDs; must be >= 1.
- CHASE_TICKS, 4, ticks per idle chase step; must be >= 1.

Ports:
- osc_clk  in  1  clock from the internal oscillator.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level; must be held until done.
- pat  in  4*NREQ  packed patterns; requester i uses pat[4i+3:4i]; 1 = LED on.
- gnt  out  NREQ  one-hot grant, 0 when no grant.
- done  out  NREQ  one-cycle pulse to the requester whose hold completed.
- busy  out  1  high in SHOW and RELEASE.
- LED  out  4  LED pins, active-low (0 = lit).

Behaviour:
- Clock and reset: one clock, osc_clk; reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE, rr_ptr = 0, chase index = 0, prescaler = 0.
  - gnt = 0, done = 0, busy = 0.
  - LED = 4'b1110 (chase step 0 lit).
  - Reset mid-SHOW aborts immediately; no done pulse.
- Outputs: all outputs are registered.
- Prescaler:
  - Free-running DIV_W-bit up counter.
  - tick = 1 for one cycle when the counter equals all-ones.
  - The counter clears to 0 on every entry into SHOW or IDLE, so periods are exact.
- States: IDLE, SHOW, RELEASE.
- IDLE:
  - LED shows ~(4'b0001 << chase_idx).
  - chase_idx advances 0→1→2→3→0 every CHASE_TICKS ticks.
  - chase_idx and the chase tick count reset to 0 on IDLE entry.
  - If any req is sampled high → SHOW at the next edge (1-cycle latency).
- Arbitration (on leaving IDLE or RELEASE):
  - Winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - After the grant, rr_ptr = (winner+1) mod NREQ.
- SHOW entry:
  - gnt = one-hot(winner), busy = 1.
  - LED = ~pat[winner], latched once; later pat changes are ignored.
  - Hold counter cleared.
- SHOW:
  - Hold counter increments on each tick.
  - When the tick brings the count to HOLD_TICKS → RELEASE.
  - SHOW therefore lasts exactly HOLD_TICKS*2^DIV_W cycles.
- SHOW abort: if req[winner] drops during SHOW → RELEASE at the next edge with no done pulse. rr_ptr keeps its advanced value.
- RELEASE (exactly 1 cycle):
  - gnt = 0, LED = 4'b1111 (all off) to give a visible gap.
  - done[winner] = 1, only if the hold completed normally.
  - busy stays 1.
  - Next: if any req → SHOW with a new arbitration; else → IDLE.
- Simultaneous events:
  - A requester whose done is pulsing while its req is still high is only eligible after the others, because rr_ptr has already moved past it.
  - A req that rises during SHOW waits for RELEASE; no preemption.
- Widths:
  - Hold counter width = clog2(HOLD_TICKS+1); chase counter width = clog2(CHASE_TICKS+1).
  - rr_ptr width = max(1, clog2(NREQ)); the wrap is an explicit compare, not a power-of-2 mask.
- NREQ=1: rr_ptr is constant 0; behaviour is otherwise identical.

Optional Feature:
- Macro: LED_SHARE_DIM_EN.
- When defined:
  - In IDLE only, the chase LED is lit only while prescaler[1:0]==2'b00 (25% duty).
  - All other cycles drive 4'b1111.
  - SHOW patterns stay full brightness.
- When undefined: the chase LED is lit continuously; no duty gating logic is present.

Test Plan (use DIV_W=4, HOLD_TICKS=3, CHASE_TICKS=2, NREQ=4):
- Reset then idle:
  - LED=1110 after reset.
  - After 32 cycles, LED=1101.
  - After a further 32 cycles, LED=1011; later steps wrap back to 1110.
- Single request:
  - req=0001, pat[0]=1010 in IDLE → next edge gnt=0001, LED=0101, busy=1.
  - 48 cycles later, one RELEASE cycle: LED=1111, done=0001, gnt=0.
  - Then IDLE with LED=1110.
- Round-robin: req=1111 held with distinct patterns → grants in order 0001, 0010, 0100, 1000, 0001. Each SHOW is 48 cycles, separated by single RELEASE cycles.
- Abort: req[2] dropped 10 cycles into its SHOW → RELEASE on the next edge, done=0, and the next grant goes to requester 3.
- Pattern latch: pat[1] changed mid-SHOW → LED unchanged until RELEASE.
- Reset mid-SHOW: rst_n low → outputs immediately at reset values; rr_ptr=0 after release of reset.
- Dim option (LED_SHARE_DIM_EN defined): in IDLE, LED=1110 on exactly 4 of every 16 cycles and 1111 otherwise.
